// File: rtl/vecacc_pkg.sv
// Shared types and default constants for vector_accumulator and its lane slice.
// Optional saturation build: VECACC_SAT_EN.
package vecacc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam int DEF_LANES      = 8;
  localparam int DEF_LANE_WIDTH = 32;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_ACC_COUNT  = 4;

  // Wide enough to hold the values 0..acc_count.
  function automatic int cnt_width(input int acc_count);
    return $clog2(acc_count + 1);
  endfunction

endpackage

// File: rtl/vecacc_lane.sv
// One lane: sign-extend the input and add it to (or load it into) the running sum.
// Combinational; clamps and flags overflow only when VECACC_SAT_EN is defined.
module vecacc_lane #(
  parameter int LANE_WIDTH = 32,
  parameter int ACC_WIDTH  = 40
) (
  input  logic [LANE_WIDTH-1:0] i_lane,
  input  logic [ACC_WIDTH-1:0]  i_acc,
  input  logic                  i_load,
`ifdef VECACC_SAT_EN
  output logic                  o_sat,
`endif
  output logic [ACC_WIDTH-1:0]  o_sum
);

`ifdef VECACC_SAT_EN
  // One guard bit above the accumulator exposes signed overflow.
  logic [ACC_WIDTH:0] w_ext_lane;
  logic [ACC_WIDTH:0] w_ext_acc;
  logic [ACC_WIDTH:0] w_sum;

  always_comb begin
    w_ext_lane = {{(ACC_WIDTH + 1 - LANE_WIDTH){i_lane[LANE_WIDTH-1]}}, i_lane};
    w_ext_acc  = i_load ? '0 : {i_acc[ACC_WIDTH-1], i_acc};
    w_sum      = w_ext_acc + w_ext_lane;
    o_sat      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    o_sum      = w_sum[ACC_WIDTH-1:0];
    if (o_sat) begin
      o_sum = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  logic [ACC_WIDTH-1:0] w_ext_lane;
  logic [ACC_WIDTH-1:0] w_ext_acc;

  always_comb begin
    w_ext_lane = {{(ACC_WIDTH - LANE_WIDTH){i_lane[LANE_WIDTH-1]}}, i_lane};
    w_ext_acc  = i_load ? '0 : i_acc;
    o_sum      = w_ext_acc + w_ext_lane;
  end
`endif

endmodule

// File: rtl/vector_accumulator.sv
// Sums ACC_COUNT signed vectors lane-wise, presenting the batch one cycle after the last strobe.
// Optional saturation build: VECACC_SAT_EN. Input cannot be stalled; a result that finds the output busy is dropped.
module vector_accumulator
  import vecacc_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int ACC_COUNT  = DEF_ACC_COUNT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LANES*LANE_WIDTH-1:0] vec_i,
  input  logic                        vec_valid_i,
  input  logic                        clear_i,
  output logic [LANES*ACC_WIDTH-1:0]  acc_o,
  output logic                        acc_valid_o,
  input  logic                        acc_ready_i,
  output logic                        busy_o,
  output logic                        drop_o,
  output logic                        sat_o
);

  localparam int CW = cnt_width(ACC_COUNT);

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [CW-1:0]                      r_count;
  logic [CW-1:0]                      w_count_nxt;
  logic [LANES-1:0][ACC_WIDTH-1:0]    r_acc;
  logic [LANES-1:0][ACC_WIDTH-1:0]    w_sum;
  logic [LANES-1:0][ACC_WIDTH-1:0]    r_acc_o;
  logic                               r_acc_vld;
  logic                               r_drop;
  logic                               w_load;
  logic                               w_acc_we;
  logic                               w_acc_clr;
  logic                               w_complete;
  logic                               w_hs;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_load      = 1'b0;
    w_acc_we    = 1'b0;
    w_acc_clr   = 1'b0;
    w_complete  = 1'b0;
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
      w_acc_clr   = 1'b1;
    end else if (vec_valid_i) begin
      w_acc_we = 1'b1;
      case (r_state)
        ST_IDLE: begin
          w_load = 1'b1;
          if (ACC_COUNT == 1) begin
            w_complete = 1'b1;
          end else begin
            w_state_nxt = ST_ACCUM;
            w_count_nxt = CW'(1);
          end
        end
        ST_ACCUM: begin
          if (r_count == CW'(ACC_COUNT - 1)) begin
            w_complete  = 1'b1;
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

`ifdef VECACC_SAT_EN
  logic [LANES-1:0] w_lane_sat;
  logic             r_sat;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vecacc_lane #(
      .LANE_WIDTH (LANE_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .i_lane (vec_i[k*LANE_WIDTH +: LANE_WIDTH]),
      .i_acc  (r_acc[k]),
      .i_load (w_load),
`ifdef VECACC_SAT_EN
      .o_sat  (w_lane_sat[k]),
`endif
      .o_sum  (w_sum[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_acc_clr) begin
      r_acc <= '0;
    end else if (w_acc_we) begin
      r_acc <= w_sum;
    end
  end

  // Output register is only replaced when empty or being drained this cycle.
  assign w_hs = r_acc_vld && acc_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_o   <= '0;
      r_acc_vld <= 1'b0;
      r_drop    <= 1'b0;
    end else if (w_complete && (!r_acc_vld || w_hs)) begin
      r_acc_o   <= w_sum;
      r_acc_vld <= 1'b1;
    end else begin
      if (w_hs) begin
        r_acc_vld <= 1'b0;
      end
      if (w_complete) begin
        r_drop <= 1'b1;
      end
    end
  end

`ifdef VECACC_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_acc_we && (|w_lane_sat)) begin
      r_sat <= 1'b1;
    end
  end
  assign sat_o = r_sat;
`else
  assign sat_o = 1'b0;
`endif

  assign acc_o       = r_acc_o;
  assign acc_valid_o = r_acc_vld;
  assign busy_o      = (r_state == ST_ACCUM);
  assign drop_o      = r_drop;

endmodule

// File: tb/tb_vector_accumulator.sv
// Bench for vector_accumulator: table of batches plus hand-written corner sequences, scoreboard on the output handshake.
// A second instance with ACC_WIDTH=33 exercises lane overflow (wrap or clamp, VECACC_SAT_EN).
module tb_vector_accumulator;

  localparam int LANES = 8;
  localparam int LW    = 32;
  localparam int AW    = 40;
  localparam int AW33  = 33;
  localparam int NV    = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [LANES*LW-1:0]   vec_i;
  logic                  vec_valid_i;
  logic                  clear_i;
  logic                  acc_ready_i;
  logic [LANES*AW-1:0]   acc_o;
  logic                  acc_valid_o, busy_o, drop_o, sat_o;
  logic [LANES*AW33-1:0] acc33_o;
  logic                  acc33_valid_o, busy33_o, drop33_o, sat33_o;

  always #5 clk = ~clk;

  vector_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .vec_i(vec_i), .vec_valid_i(vec_valid_i), .clear_i(clear_i),
    .acc_o(acc_o), .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
    .busy_o(busy_o), .drop_o(drop_o), .sat_o(sat_o)
  );

  vector_accumulator #(.ACC_WIDTH(AW33)) u_dut33 (
    .clk(clk), .rst_n(rst_n), .vec_i(vec_i), .vec_valid_i(vec_valid_i), .clear_i(clear_i),
    .acc_o(acc33_o), .acc_valid_o(acc33_valid_o), .acc_ready_i(acc_ready_i),
    .busy_o(busy33_o), .drop_o(drop33_o), .sat_o(sat33_o)
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [LANES*AW-1:0] exp_q[$];

  typedef struct {
    logic [LANES*LW-1:0] vec [NV];
    logic [LANES*AW-1:0] exp;
    string               name;
  } row_t;
  row_t tbl [5];

  task automatic check(input string name, input logic [LANES*AW-1:0] act, input logic [LANES*AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LANES*LW-1:0] rep(input logic [LW-1:0] v);
    logic [LANES*LW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*LW +: LW] = v;
    return r;
  endfunction

  function automatic logic [LANES*AW-1:0] repa(input logic [AW-1:0] v);
    logic [LANES*AW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*AW +: AW] = v;
    return r;
  endfunction

  // Caller is at a falling edge; returns one falling edge later with the strobe removed.
  task automatic strobe(input logic [LANES*LW-1:0] v, input logic clr);
    vec_i       = v;
    vec_valid_i = 1'b1;
    clear_i     = clr;
    @(negedge clk);
    vec_valid_i = 1'b0;
    clear_i     = 1'b0;
  endtask

  task automatic batch(input logic [LANES*LW-1:0] a, input logic [LANES*LW-1:0] b,
                       input logic [LANES*LW-1:0] c, input logic [LANES*LW-1:0] d);
    strobe(a, 1'b0);
    strobe(b, 1'b0);
    strobe(c, 1'b0);
    strobe(d, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard: every accepted result must match the oldest expectation.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && acc_valid_o && acc_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_result: got %h expected none", acc_o);
      end else begin
        check("scoreboard", acc_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW33-1:0] exp33;
    logic            exp_sat33;
    logic [LW-1:0]   lv;
    logic [31:0]     s_bits;

    rst_n = 1'b0; vec_i = '0; vec_valid_i = 1'b0; clear_i = 1'b0; acc_ready_i = 1'b1;

    tbl[0].vec[0] = rep(32'd1); tbl[0].vec[1] = rep(32'd2);
    tbl[0].vec[2] = rep(32'd3); tbl[0].vec[3] = rep(32'd4);
    tbl[0].exp = repa(40'd10); tbl[0].name = "basic_sum";
    tbl[1].vec[0] = rep(32'hFFFF_FFFB); tbl[1].vec[1] = rep(32'd3);
    tbl[1].vec[2] = rep(32'd0); tbl[1].vec[3] = rep(32'd0);
    tbl[1].exp = repa(40'hFF_FFFF_FFFE); tbl[1].name = "signed_sum";
    for (int j = 0; j < NV; j++) tbl[2].vec[j] = rep(32'h7FFF_FFFF);
    tbl[2].exp = repa(40'h01_FFFF_FFFC); tbl[2].name = "max_pos";
    for (int j = 0; j < NV; j++) tbl[3].vec[j] = rep(32'h8000_0000);
    tbl[3].exp = repa(40'hFE_0000_0000); tbl[3].name = "max_neg";
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < NV; j++) begin
        lv = 32'((k - 4) * (j + 1));
        tbl[4].vec[j][k*LW +: LW] = lv;
      end
      s_bits = 32'((k - 4) * 10);
      tbl[4].exp[k*AW +: AW] = {{(AW-32){s_bits[31]}}, s_bits};
    end
    tbl[4].name = "mixed_lanes";

    #1;
    check("reset_acc_o", acc_o, '0);
    check("reset_acc_valid", acc_valid_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_drop", drop_o, 0);
    check("reset_sat", sat_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Lane overflow on the 33-bit instance.
`ifdef VECACC_SAT_EN
    exp33 = 33'h0_FFFF_FFFF; exp_sat33 = 1'b1;
`else
    exp33 = 33'h1_FFFF_FFFC; exp_sat33 = 1'b0;
`endif
    strobe(rep(32'h7FFF_FFFF), 1'b0);
    strobe(rep(32'h7FFF_FFFF), 1'b0);
    strobe(rep(32'h7FFF_FFFF), 1'b0);
    exp_q.push_back(repa(40'h01_FFFF_FFFC));
    strobe(rep(32'h7FFF_FFFF), 1'b0);
    check("sat33_valid", acc33_valid_o, 1);
    check("sat33_lane0", acc33_o[AW33-1:0], exp33);
    check("sat33_flag", sat33_o, exp_sat33);
    check("sat40_flag", sat_o, 0);
    @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < NV; j++) begin
        if (j == NV - 1) exp_q.push_back(tbl[r].exp);
        strobe(tbl[r].vec[j], 1'b0);
        if (j == 0) check({tbl[r].name, "_busy"}, busy_o, 1);
      end
      check({tbl[r].name, "_valid_rise"}, acc_valid_o, 1);
      check({tbl[r].name, "_idle"}, busy_o, 0);
      @(negedge clk);
      check({tbl[r].name, "_valid_fall"}, acc_valid_o, 0);
    end

    // Clear with the second strobe discards that vector and the partial batch.
    strobe(rep(32'd1), 1'b0);
    strobe(rep(32'd5), 1'b1);
    check("clear_busy", busy_o, 0);
    strobe(rep(32'd1), 1'b0);
    strobe(rep(32'd2), 1'b0);
    strobe(rep(32'd3), 1'b0);
    exp_q.push_back(repa(40'd10));
    strobe(rep(32'd4), 1'b0);
    check("clear_valid", acc_valid_o, 1);
    @(negedge clk);

    // Backpressure across two batches: second is dropped.
    do_reset();
    acc_ready_i = 1'b0;
    exp_q.push_back(repa(40'd10));
    batch(rep(32'd1), rep(32'd2), rep(32'd3), rep(32'd4));
    check("bp_first_valid", acc_valid_o, 1);
    check("bp_first_nodrop", drop_o, 0);
    batch(rep(32'd5), rep(32'd5), rep(32'd5), rep(32'd5));
    check("bp_held_valid", acc_valid_o, 1);
    check("bp_held_value", acc_o, repa(40'd10));
    check("bp_drop", drop_o, 1);
    acc_ready_i = 1'b1;
    @(negedge clk);
    check("bp_valid_fall", acc_valid_o, 0);
    check("bp_drop_sticky", drop_o, 1);

    // Completion in the handshake cycle replaces the result without a drop.
    do_reset();
    acc_ready_i = 1'b0;
    exp_q.push_back(repa(40'd10));
    batch(rep(32'd1), rep(32'd2), rep(32'd3), rep(32'd4));
    strobe(rep(32'd2), 1'b0);
    strobe(rep(32'd2), 1'b0);
    strobe(rep(32'd2), 1'b0);
    acc_ready_i = 1'b1;
    exp_q.push_back(repa(40'd8));
    strobe(rep(32'd2), 1'b0);
    check("hs_new_valid", acc_valid_o, 1);
    check("hs_new_value", acc_o, repa(40'd8));
    check("hs_nodrop", drop_o, 0);
    @(negedge clk);

    // Reset mid-batch: nothing emerges, and counting restarts from zero.
    strobe(rep(32'd1), 1'b0);
    strobe(rep(32'd1), 1'b0);
    strobe(rep(32'd1), 1'b0);
    check("rst_mid_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_acc_o", acc_o, '0);
    check("rst_mid_valid", acc_valid_o, 0);
    check("rst_mid_busy_low", busy_o, 0);
    check("rst_mid_drop", drop_o, 0);
    check("rst_mid_sat", sat_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_after_valid", acc_valid_o, 0);
    check("rst_after_busy", busy_o, 0);
    exp_q.push_back(repa(40'd10));
    batch(rep(32'd1), rep(32'd2), rep(32'd3), rep(32'd4));
    check("rst_restart_valid", acc_valid_o, 1);
    repeat (3) @(negedge clk);

    check("queue_drained", 320'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
